debounce_multi_one_shot: RTL

- N-channel FSM debouncer with per-channel one-shot outputs; generalises the single-button debounce/one-shot used on the board buttons.
- Adds input synchronisation, a selectable trigger edge, a stable debounced level output, and optional hold-to-repeat pulses.
- Sits between raw board buttons/switches and the MCU input ports. One instance serves a whole button bank.

---
 rtl/debounce_multi_one_shot.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/debounce_multi_one_shot.sv
// rtl/debounce_multi_one_shot.sv - N-channel button debouncer with per-channel one-shot and hold-to-repeat
module debounce_multi_one_shot #(
  parameter int N_CH          = 4,
  parameter int RISE_CLKS     = 25,
  parameter int FALL_CLKS     = 50,
  parameter int PULSE_CLKS    = 3,
  parameter bit TRIG_ON_PRESS = 1'b0,
  parameter int REPEAT_DLY    = 0,
  parameter int REPEAT_PER    = 0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_CH-1:0] BTN,
  output logic [N_CH-1:0] DB_LEVEL,
  output logic [N_CH-1:0] DB_BTN
);

  localparam int DB_MAX  = (RISE_CLKS > FALL_CLKS) ? RISE_CLKS : FALL_CLKS;
  localparam int CNT_MAX = (DB_MAX > PULSE_CLKS) ? DB_MAX : PULSE_CLKS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int REP_M0  = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int REP_MAX = (REP_M0 > 1) ? REP_M0 : 1;
  localparam int RW      = $clog2(REP_MAX + 1);

  localparam logic [CW-1:0] RISE_C  = CW'(RISE_CLKS);
  localparam logic [CW-1:0] FALL_C  = CW'(FALL_CLKS);
  localparam logic [CW-1:0] PULSE_C = CW'(PULSE_CLKS);
  localparam logic [RW-1:0] DLY_C   = RW'(REPEAT_DLY);
  localparam logic [RW-1:0] PER_C   = RW'(REPEAT_PER);

  localparam logic [1:0] ST_LOW  = 2'd0;
  localparam logic [1:0] ST_L2H  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_H2L  = 2'd3;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic          sync0, s;
    logic [1:0]    state, state_d;
    logic [CW-1:0] cnt, cnt_d, pcnt;
    logic [RW-1:0] rcnt, rcnt_nxt;
    logic          rphase, level, level_d, pulse;
    logic          st_bad, rise, fall, rep_fire, trig;

    always_comb begin
      state_d = state;
      cnt_d   = cnt;
      level_d = level;
      st_bad  = 1'b0;
      case (state)
        ST_LOW: begin
          if (s) begin
            state_d = ST_L2H;
            cnt_d   = CW'(1);
          end else begin
            cnt_d = '0;
          end
        end
        ST_L2H: begin
          if (!s) begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end else if (cnt == RISE_C) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
            level_d = 1'b1;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
        ST_HIGH: begin
          if (!s) begin
            state_d = ST_H2L;
            cnt_d   = CW'(1);
          end else begin
            cnt_d = '0;
          end
        end
        ST_H2L: begin
          if (s) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end else if (cnt == FALL_C) begin
            state_d = ST_LOW;
            cnt_d   = '0;
            level_d = 1'b0;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
        default: begin
          state_d = ST_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
          st_bad  = 1'b1;
        end
      endcase
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        sync0 <= 1'b0;
        s     <= 1'b0;
        state <= ST_LOW;
        cnt   <= '0;
        level <= 1'b0;
      end else begin
        sync0 <= BTN[i];
        s     <= sync0;
        state <= state_d;
        cnt   <= cnt_d;
        level <= level_d;
      end
    end

    assign rise = level_d & ~level;
    assign fall = level & ~level_d;

    // Repeat timer counts clocks spent with the debounced level high.
    always_comb begin
      rcnt_nxt = rcnt + RW'(1);
      rep_fire = 1'b0;
      if (REPEAT_DLY > 0 && level) begin
        if (!rphase)
          rep_fire = (rcnt_nxt == DLY_C);
        else if (REPEAT_PER > 0)
          rep_fire = (rcnt_nxt == PER_C);
      end
    end

    always_ff @(posedge CLK) begin
      if (RST || !level) begin
        rcnt   <= '0;
        rphase <= 1'b0;
      end else if (REPEAT_DLY > 0) begin
        if (rep_fire) begin
          rcnt   <= '0;
          rphase <= 1'b1;
        end else if (!rphase || REPEAT_PER > 0) begin
          rcnt <= rcnt_nxt;
        end
      end
    end

    assign trig = (TRIG_ON_PRESS ? rise : fall) | rep_fire;

    // A trigger that lands while the pulse is running is dropped.
    always_ff @(posedge CLK) begin
      if (RST || st_bad) begin
        pulse <= 1'b0;
        pcnt  <= '0;
      end else if (pulse) begin
        if (pcnt == PULSE_C) begin
          pulse <= 1'b0;
          pcnt  <= '0;
        end else begin
          pcnt <= pcnt + CW'(1);
        end
      end else if (trig) begin
        pulse <= 1'b1;
        pcnt  <= CW'(1);
      end
    end

    assign DB_LEVEL[i] = level;
    assign DB_BTN[i]   = pulse;
  end

endmodule
